mimo_tx_encoder: RTL and testbench

- Transmit-side counterpart of the sphere-decoding MIMO detector: takes a 12-bit word of four 3-bit Gray-coded 8-PSK symbol labels and a stored 4x4 complex channel matrix R, and produces the noiseless received vector y = R*s.
- Output uses the detector's 128-bit data-word format, so it drives the detector bench directly and serves as a golden stimulus generator.

---
 rtl/mimo_tx_encoder_pkg.sv | 100 ++++++++++
 rtl/mimo_tx_encoder_cmac.sv | 36 +++
 rtl/mimo_tx_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_mimo_tx_encoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mimo_tx_encoder_pkg.sv
// Shared definitions for the MIMO transmit encoder: fixed-point format, 8-PSK
// constellation, Gray label tables, FSM encodings and the output scaler.
package mimo_tx_encoder_pkg;

  localparam int INT_W  = 6;
  localparam int FRAC_W = 10;
  localparam int WIDTH  = INT_W + FRAC_W;
  localparam int CPLX_W = 2 * WIDTH;
  localparam int PROD_W = 2 * WIDTH + 1;
  localparam int ACC_W  = 36;

  localparam logic [WIDTH-1:0] Q_ZERO    = 16'h0000;
  localparam logic [WIDTH-1:0] Q_ONE     = 16'h0400;
  localparam logic [WIDTH-1:0] Q_NEG_ONE = 16'hFC00;
  localparam logic [WIDTH-1:0] Q_C       = 16'h02D4;
  localparam logic [WIDTH-1:0] Q_NEG_C   = 16'hFD2C;
  localparam logic [WIDTH-1:0] Q_MAX     = 16'h7FFF;
  localparam logic [WIDTH-1:0] Q_MIN     = 16'h8000;

  localparam logic signed [ACC_W-1:0] Y_MAX = 36'sd32767;
  localparam logic signed [ACC_W-1:0] Y_MIN = -36'sd32768;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  typedef struct packed {
    logic             sat;
    logic [WIDTH-1:0] val;
  } scaled_t;

  function automatic logic [2:0] gray2idx(input logic [2:0] g);
    case (g)
      3'd0:    return 3'd0;
      3'd1:    return 3'd1;
      3'd2:    return 3'd3;
      3'd3:    return 3'd2;
      3'd4:    return 3'd7;
      3'd5:    return 3'd6;
      3'd6:    return 3'd4;
      3'd7:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Inverse table, used by the detector when it swaps indices back to labels.
  function automatic logic [2:0] idx2gray(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd0;
      3'd1:    return 3'd1;
      3'd2:    return 3'd3;
      3'd3:    return 3'd2;
      3'd4:    return 3'd6;
      3'd5:    return 3'd7;
      3'd6:    return 3'd5;
      3'd7:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [CPLX_W-1:0] const_point(input logic [2:0] idx);
    case (idx)
      3'd0:    return {Q_NEG_ONE, Q_ZERO};
      3'd1:    return {Q_NEG_C,   Q_C};
      3'd2:    return {Q_ZERO,    Q_ONE};
      3'd3:    return {Q_C,       Q_C};
      3'd4:    return {Q_ONE,     Q_ZERO};
      3'd5:    return {Q_C,       Q_NEG_C};
      3'd6:    return {Q_ZERO,    Q_NEG_ONE};
      3'd7:    return {Q_NEG_C,   Q_NEG_C};
      default: return {Q_ZERO,    Q_ZERO};
    endcase
  endfunction

  function automatic logic [CPLX_W-1:0] gray_to_point(input logic [2:0] g);
    return const_point(gray2idx(g));
  endfunction

  // Floor-scale an accumulator back to Q6.10 and clamp to the signed range.
  function automatic scaled_t scale_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    scaled_t                 res;
    sh = acc >>> FRAC_W;
    if (sh > Y_MAX) begin
      res.sat = 1'b1;
      res.val = Q_MAX;
    end else if (sh < Y_MIN) begin
      res.sat = 1'b1;
      res.val = Q_MIN;
    end else begin
      res.sat = 1'b0;
      res.val = sh[WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mimo_tx_encoder_cmac.sv
// Combinational full-precision complex multiply of two {re, im} operands.
module mimo_cmac
  import mimo_tx_encoder_pkg::*;
(
  input  logic        [CPLX_W-1:0] a,
  input  logic        [CPLX_W-1:0] b,
  output logic signed [PROD_W-1:0] p_re,
  output logic signed [PROD_W-1:0] p_im
);

  localparam int MUL_W = 2 * WIDTH;

  logic signed [WIDTH-1:0] ar_s;
  logic signed [WIDTH-1:0] ai_s;
  logic signed [WIDTH-1:0] br_s;
  logic signed [WIDTH-1:0] bi_s;
  logic signed [MUL_W-1:0] rr_s;
  logic signed [MUL_W-1:0] ii_s;
  logic signed [MUL_W-1:0] ri_s;
  logic signed [MUL_W-1:0] ir_s;

  assign ar_s = a[CPLX_W-1:WIDTH];
  assign ai_s = a[WIDTH-1:0];
  assign br_s = b[CPLX_W-1:WIDTH];
  assign bi_s = b[WIDTH-1:0];

  assign rr_s = MUL_W'(ar_s) * MUL_W'(br_s);
  assign ii_s = MUL_W'(ai_s) * MUL_W'(bi_s);
  assign ri_s = MUL_W'(ar_s) * MUL_W'(bi_s);
  assign ir_s = MUL_W'(ai_s) * MUL_W'(br_s);

  // One extra bit keeps the sum/difference exact for full-scale inputs.
  assign p_re = PROD_W'(rr_s) - PROD_W'(ii_s);
  assign p_im = PROD_W'(ri_s) + PROD_W'(ir_s);

endmodule

// File: rtl/mimo_tx_encoder.sv
// MIMO transmit encoder: maps four Gray 8-PSK labels to symbols and produces
// the noiseless received vector y = R*s, one complex MAC per clock.
module mimo_tx_encoder
  import mimo_tx_encoder_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 i_r_valid,
  input  logic [8*WIDTH-1:0]   i_r_data,
  output logic                 o_r_ready,
  input  logic                 i_sym_valid,
  input  logic [11:0]          i_sym,
  output logic                 o_sym_ready,
  output logic                 o_valid,
  output logic [8*WIDTH-1:0]   o_data,
  input  logic                 i_ready,
  output logic                 o_sat
);

  state_t                   state_r;
  state_t                   state_s;
  logic [1:0]               cnt_r;
  logic [3:0]               mac_cnt_r;
  logic [11:0]              sym_r;
  logic signed [ACC_W-1:0]  acc_re_r;
  logic signed [ACC_W-1:0]  acc_im_r;
  logic signed [ACC_W-1:0]  acc_re_s;
  logic signed [ACC_W-1:0]  acc_im_s;
  logic [CPLX_W-1:0]        r_mem_r [4][4];
  logic [CPLX_W-1:0]        y_r [4];
  logic                     valid_r;
  logic [8*WIDTH-1:0]       data_r;
  logic                     sat_r;

  logic                     r_fire_s;
  logic                     sym_fire_s;
  logic                     mac_s;
  logic                     row_end_s;
  logic [1:0]               wr_row_s;
  logic [1:0]               row_s;
  logic [1:0]               col_s;
  logic [2:0]               label_s;
  logic [CPLX_W-1:0]        r_elem_s;
  logic [CPLX_W-1:0]        s_elem_s;
  logic signed [PROD_W-1:0] p_re_s;
  logic signed [PROD_W-1:0] p_im_s;
  scaled_t                  y_re_s;
  scaled_t                  y_im_s;

  assign o_valid = valid_r;
  assign o_data  = data_r;
  assign o_sat   = sat_r;

  assign r_fire_s   = i_r_valid & o_r_ready;
  assign sym_fire_s = i_sym_valid & o_sym_ready;
  assign mac_s      = (state_r == S_MAC);
  assign row_s      = mac_cnt_r[3:2];
  assign col_s      = mac_cnt_r[1:0];
  assign row_end_s  = (col_s == 2'd3);
  assign wr_row_s   = (state_r == S_IDLE) ? 2'd0 : cnt_r;

  // Next-state logic and input readies; R rows win over symbols in S_IDLE
  always_comb begin
    state_s     = state_r;
    o_r_ready   = 1'b0;
    o_sym_ready = 1'b0;
    case (state_r)
      S_LOAD: begin
        o_r_ready = 1'b1;
        if (i_r_valid && (cnt_r == 2'd3)) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_LOAD;
        end
      end
      S_IDLE: begin
        o_r_ready   = 1'b1;
        o_sym_ready = ~i_r_valid;
        if (i_r_valid) begin
          state_s = S_LOAD;
        end else if (i_sym_valid) begin
          state_s = S_MAC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MAC: begin
        if (mac_cnt_r == 4'd15) begin
          state_s = S_OUT;
        end else begin
          state_s = S_MAC;
        end
      end
      S_OUT: begin
        if (valid_r && i_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_OUT;
        end
      end
      default: begin
        state_s = S_LOAD;
      end
    endcase
  end

  // Operand select for the current MAC step
  always_comb begin
    r_elem_s = r_mem_r[row_s][col_s];
    case (col_s)
      2'd0:    label_s = sym_r[11:9];
      2'd1:    label_s = sym_r[8:6];
      2'd2:    label_s = sym_r[5:3];
      2'd3:    label_s = sym_r[2:0];
      default: label_s = sym_r[2:0];
    endcase
    s_elem_s = gray_to_point(label_s);
  end

  mimo_cmac u_cmac (
    .a    (r_elem_s),
    .b    (s_elem_s),
    .p_re (p_re_s),
    .p_im (p_im_s)
  );

  assign acc_re_s = acc_re_r + ACC_W'(p_re_s);
  assign acc_im_s = acc_im_r + ACC_W'(p_im_s);
  assign y_re_s   = scale_sat(acc_re_s);
  assign y_im_s   = scale_sat(acc_im_s);

  // FSM state, row/MAC counters, latched symbol word and accumulators
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= S_LOAD;
      cnt_r     <= 2'd0;
      mac_cnt_r <= 4'd0;
      sym_r     <= 12'd0;
      acc_re_r  <= {ACC_W{1'b0}};
      acc_im_r  <= {ACC_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (r_fire_s) begin
        cnt_r <= (state_r == S_IDLE) ? 2'd1 : (cnt_r + 2'd1);
      end
      if (sym_fire_s) begin
        sym_r     <= i_sym;
        mac_cnt_r <= 4'd0;
        acc_re_r  <= {ACC_W{1'b0}};
        acc_im_r  <= {ACC_W{1'b0}};
      end else if (mac_s) begin
        mac_cnt_r <= mac_cnt_r + 4'd1;
        if (row_end_s) begin
          acc_re_r <= {ACC_W{1'b0}};
          acc_im_r <= {ACC_W{1'b0}};
        end else begin
          acc_re_r <= acc_re_s;
          acc_im_r <= acc_im_s;
        end
      end
    end
  end

  // Channel matrix storage; a row from S_IDLE always restarts at row 0
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          r_mem_r[r][c] <= {CPLX_W{1'b0}};
        end
      end
    end else if (r_fire_s) begin
      for (int c = 0; c < 4; c++) begin
        r_mem_r[wr_row_s][c] <= i_r_data[8*WIDTH-1-CPLX_W*c -: CPLX_W];
      end
    end
  end

  // Per-row results and the sticky saturation flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < 4; r++) begin
        y_r[r] <= {CPLX_W{1'b0}};
      end
      sat_r <= 1'b0;
    end else begin
      if (r_fire_s && (state_r == S_IDLE)) begin
        sat_r <= 1'b0;
      end else if (mac_s && row_end_s && (y_re_s.sat || y_im_s.sat)) begin
        sat_r <= 1'b1;
      end
      if (mac_s && row_end_s) begin
        y_r[row_s] <= {y_re_s.val, y_im_s.val};
      end
    end
  end

  // Output register: first S_OUT cycle publishes y, then holds until accepted
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_r <= 1'b0;
      data_r  <= {(8*WIDTH){1'b0}};
    end else if (state_r == S_OUT) begin
      if (!valid_r) begin
        valid_r <= 1'b1;
        data_r  <= {y_r[0], y_r[1], y_r[2], y_r[3]};
      end else if (i_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mimo_tx_encoder.sv
// Directed scoreboard bench for mimo_tx_encoder: an integer reference model
// of y = R*s predicts each output word at symbol accept time.
module tb_mimo_tx_encoder;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         i_r_valid;
  logic [127:0] i_r_data;
  logic         o_r_ready;
  logic         i_sym_valid;
  logic [11:0]  i_sym;
  logic         o_sym_ready;
  logic         o_valid;
  logic [127:0] o_data;
  logic         i_ready;
  logic         o_sat;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [128:0] exp_q[$];
  logic [31:0]  m_r [4][4];
  int           ld_cnt;
  logic         sat_m;
  time          t_acc;
  logic [127:0] got;
  logic [127:0] held;
  logic [128:0] e;
  int           k;
  int           n_rise;
  logic [2:0]   lab;

  logic [31:0] lut_t [8] = '{32'hFC00_0000, 32'hFD2C_02D4, 32'h0000_0400, 32'h02D4_02D4,
                             32'h0400_0000, 32'h02D4_FD2C, 32'h0000_FC00, 32'hFD2C_FD2C};
  int g2i_t [8] = '{0, 1, 3, 2, 7, 6, 4, 5};

  localparam logic [127:0] I0 = 128'h0400_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] I1 = 128'h0000_0000_0400_0000_0000_0000_0000_0000;
  localparam logic [127:0] I2 = 128'h0000_0000_0000_0000_0400_0000_0000_0000;
  localparam logic [127:0] I3 = 128'h0000_0000_0000_0000_0000_0000_0400_0000;

  mimo_tx_encoder dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_r_valid   (i_r_valid),
    .i_r_data    (i_r_data),
    .o_r_ready   (o_r_ready),
    .i_sym_valid (i_sym_valid),
    .i_sym       (i_sym),
    .o_sym_ready (o_sym_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready),
    .o_sat       (o_sat)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [128:0] model(input logic [11:0] sym, input logic sat_in);
    logic [127:0] y;
    logic         sat;
    logic [2:0]   g;
    longint       ar, ai, br, bi, are, aim, sre, sim;
    sat = sat_in;
    y   = 128'h0;
    for (int r = 0; r < 4; r++) begin
      are = 0;
      aim = 0;
      for (int c = 0; c < 4; c++) begin
        g   = sym[11-3*c -: 3];
        ar  = $signed(m_r[r][c][31:16]);
        ai  = $signed(m_r[r][c][15:0]);
        br  = $signed(lut_t[g2i_t[g]][31:16]);
        bi  = $signed(lut_t[g2i_t[g]][15:0]);
        are = are + ar * br - ai * bi;
        aim = aim + ar * bi + ai * br;
      end
      sre = are >>> 10;
      sim = aim >>> 10;
      if (sre > 32767) begin sre = 32767; sat = 1'b1; end
      else if (sre < -32768) begin sre = -32768; sat = 1'b1; end
      if (sim > 32767) begin sim = 32767; sat = 1'b1; end
      else if (sim < -32768) begin sim = -32768; sat = 1'b1; end
      y[127-32*r -: 32] = {sre[15:0], sim[15:0]};
    end
    return {sat, y};
  endfunction

  // Call just after a falling edge; returns just after the next falling edge.
  task automatic send_row(input logic [127:0] d);
    int w;
    i_r_valid = 1'b1;
    i_r_data  = d;
    #1;
    w = 0;
    while (!o_r_ready && w < 100) begin @(negedge Clk); #1; w++; end
    chk("r_ready", o_r_ready, 1'b1);
    if (ld_cnt == 0) sat_m = 1'b0;
    for (int c = 0; c < 4; c++) m_r[ld_cnt][c] = d[127-32*c -: 32];
    ld_cnt = (ld_cnt + 1) % 4;
    @(posedge Clk);
    @(negedge Clk);
    i_r_valid = 1'b0;
  endtask

  task automatic load_mat(input logic [127:0] r0, input logic [127:0] r1,
                          input logic [127:0] r2, input logic [127:0] r3);
    send_row(r0);
    send_row(r1);
    send_row(r2);
    send_row(r3);
  endtask

  task automatic accept_sym(input logic [11:0] sym);
    int w;
    logic [128:0] p;
    i_sym_valid = 1'b1;
    i_sym       = sym;
    #1;
    w = 0;
    while (!o_sym_ready && w < 100) begin @(negedge Clk); #1; w++; end
    chk("sym_ready", o_sym_ready, 1'b1);
    p = model(sym, sat_m);
    sat_m = p[128];
    exp_q.push_back(p);
    @(posedge Clk);
    t_acc = $time;
    @(negedge Clk);
    i_sym_valid = 1'b0;
  endtask

  task automatic collect(input bit chk_lat, output logic [127:0] obs);
    int w;
    logic [128:0] ex;
    w = 0;
    do begin @(posedge Clk); #1; w++; end while (!o_valid && w < 100);
    chk("o_valid_rise", o_valid, 1'b1);
    if (chk_lat) chk("latency", ($time - 1 - t_acc) / 10, 17);
    obs = o_data;
    chk("sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      chk("y_data", o_data, ex[127:0]);
      chk("o_sat", o_sat, ex[128]);
    end
    @(posedge Clk);
    #1;
    chk("o_valid_drop", o_valid, 1'b0);
    chk("o_data_hold", o_data, obs);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; i_r_valid = 1'b0; i_r_data = 128'h0;
    i_sym_valid = 1'b0; i_sym = 12'h0; i_ready = 1'b1;
    ld_cnt = 0; sat_m = 1'b0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m_r[r][c] = 32'h0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_data", o_data, 128'h0);
    chk("rst_o_sat", o_sat, 1'b0);
    chk("rst_o_r_ready", o_r_ready, 1'b1);
    chk("rst_o_sym_ready", o_sym_ready, 1'b0);
    @(negedge Clk);

    // identity channel
    load_mat(I0, I1, I2, I3);
    accept_sym(12'o0123);
    collect(1'b1, got);
    chk("identity_const", got, 128'hFC00_0000_FD2C_02D4_02D4_02D4_0000_0400);

    // Gray label sweep, same label on every antenna
    for (int g = 0; g < 8; g++) begin
      lab = g[2:0];
      accept_sym({lab, lab, lab, lab});
      collect(1'b1, got);
      if (g == 4) chk("gray4_y0", got[127:96], 32'hFD2C_FD2C);
      if (g == 7) chk("gray7_y0", got[127:96], 32'h02D4_FD2C);
    end

    // upper-triangular row 0 = {2, 1, 0, 0}
    load_mat(128'h0800_0000_0400_0000_0000_0000_0000_0000, I1, I2, I3);
    accept_sym(12'o4444);
    collect(1'b1, got);
    chk("ut_y0", got[127:96], 32'hF784_F784);
    chk("ut_sat", o_sat, 1'b0);

    // saturation, cleared by the next load
    load_mat({4{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, {4{32'h7FFF_0000}});
    accept_sym(12'o6666);
    collect(1'b1, got);
    chk("sat_data", got, {4{32'h7FFF_0000}});
    chk("sat_flag", o_sat, 1'b1);
    load_mat(I0, I1, I2, I3);
    #1;
    chk("sat_cleared", o_sat, 1'b0);

    // backpressure: hold i_ready low with a second symbol waiting
    i_ready = 1'b0;
    accept_sym(12'o0257);
    k = 0;
    do begin @(posedge Clk); #1; k++; end while (!o_valid && k < 100);
    chk("bp_valid", o_valid, 1'b1);
    @(negedge Clk);
    held = o_data;
    i_sym_valid = 1'b1;
    i_sym = 12'o7310;
    for (int s = 0; s < 10; s++) begin
      #1;
      chk("bp_valid_hold", o_valid, 1'b1);
      chk("bp_data_stable", o_data, held);
      chk("bp_sym_ready", o_sym_ready, 1'b0);
      @(negedge Clk);
    end
    i_ready = 1'b1;
    chk("bp_sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("bp_data", held, e[127:0]);
    end
    @(posedge Clk);
    @(negedge Clk);
    accept_sym(12'o7310);
    collect(1'b1, got);

    // R row and symbol offered together in S_IDLE
    i_r_valid = 1'b1;
    i_r_data = 128'h0000_0400_0400_0000_0000_0000_0000_0000;
    i_sym_valid = 1'b1;
    i_sym = 12'o1357;
    #1;
    chk("prio_sym_ready", o_sym_ready, 1'b0);
    chk("prio_r_ready", o_r_ready, 1'b1);
    send_row(128'h0000_0400_0400_0000_0000_0000_0000_0000);
    #1;
    chk("prio_load_sym_ready", o_sym_ready, 1'b0);
    send_row(I1);
    send_row(I2);
    send_row(I3);
    i_sym_valid = 1'b0;
    accept_sym(12'o1357);
    collect(1'b1, got);

    // reset during MAC cycle 7
    accept_sym(12'o2222);
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("mrst_o_valid", o_valid, 1'b0);
    chk("mrst_o_r_ready", o_r_ready, 1'b1);
    chk("mrst_o_sym_ready", o_sym_ready, 1'b0);
    chk("mrst_o_data", o_data, 128'h0);
    chk("mrst_o_sat", o_sat, 1'b0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    ld_cnt = 0;
    sat_m = 1'b0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m_r[r][c] = 32'h0;
    @(negedge Clk);
    Reset = 1'b0;
    i_sym_valid = 1'b1;
    i_sym = 12'o5670;
    n_rise = 0;
    repeat (30) begin
      @(posedge Clk);
      #1;
      if (o_valid) n_rise++;
    end
    chk("mrst_no_y", n_rise, 0);
    chk("mrst_load_sym_ready", o_sym_ready, 1'b0);
    @(negedge Clk);
    i_sym_valid = 1'b0;
    load_mat(I0, I1, I2, I3);
    accept_sym(12'o5670);
    collect(1'b1, got);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
